// File: rtl/qhttp_pkg.sv
// qhttp_pkg: message/event codes, slot and issue-FSM encodings, default widths
// shared by the qhttp session scheduler and its earliest-deadline selector.
package qhttp_pkg;
    localparam int ID_W_DEF = 128;
    localparam int TS_W_DEF = 64;
    localparam logic [7:0] MSG_ALLOC_REQ          = 8'h01;
    localparam logic [7:0] MSG_BELL_RESULT        = 8'h02;
    localparam logic [7:0] MSG_GATE_REQ           = 8'h03;
    localparam logic [7:0] EVT_CORRECTION_APPLIED = 8'h04;
    localparam logic [7:0] EVT_EXPIRED            = 8'h05;
    typedef enum logic [1:0] {SLOT_FREE, SLOT_WAIT_BELL, SLOT_READY, SLOT_ISSUED} slot_state_e;
    typedef enum logic {ISS_IDLE, ISS_ISSUE} issue_state_e;
endpackage

// File: rtl/qhttp_edf_select.sv
// qhttp_edf_select: combinational earliest-deadline-first pick over a valid mask;
// strict less-than while scanning upward keeps the lowest index on a tie.
module qhttp_edf_select #(
    parameter int N    = 8,
    parameter int TS_W = 64,
    parameter int IW   = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]           valid_i,
    input  logic [N-1:0][TS_W-1:0] deadline_i,
    output logic [N-1:0]           grant_o,
    output logic [IW-1:0]          idx_o,
    output logic                   any_o
);
    logic [TS_W-1:0] best;
    always_comb begin
        any_o = 1'b0;
        idx_o = '0;
        best  = '0;
        for (int i = 0; i < N; i++) begin
            if (valid_i[i] && (!any_o || deadline_i[i] < best)) begin
                any_o = 1'b1;
                idx_o = IW'(i);
                best  = deadline_i[i];
            end
        end
        grant_o = any_o ? (N'(1) << idx_o) : '0;
    end
endmodule

// File: rtl/qhttp_session_scheduler.sv
// qhttp_session_scheduler: pairs allocated teleportation sessions with Bell results,
// issues Pauli corrections earliest-deadline-first and evicts sessions past their guard.
module qhttp_session_scheduler
    import qhttp_pkg::*;
#(
    parameter int NUM_SLOTS = 8,
    parameter int ID_W      = ID_W_DEF,
    parameter int TS_W      = TS_W_DEF,
    parameter int PRIO_MAX  = 100,
    parameter int GUARD     = 16
) (
    input  logic                             clk_1g,
    input  logic                             rst_n,
    input  logic                             alloc_valid,
    output logic                             alloc_ready,
    input  logic [ID_W-1:0]                  alloc_qubit_id,
    input  logic [TS_W-1:0]                  alloc_deadline,
    input  logic [7:0]                       alloc_priority,
    input  logic                             emergency_override,
    input  logic                             bell_valid,
    input  logic [ID_W-1:0]                  bell_qubit_id,
    input  logic [1:0]                       bell_result,
    output logic                             apply_gate,
    output logic [1:0]                       pauli_gate,
    output logic [ID_W-1:0]                  gate_qubit_id,
    input  logic                             gate_ack,
    output logic                             evt_valid,
    output logic [7:0]                       evt_code,
    output logic [ID_W-1:0]                  evt_qubit_id,
    output logic [TS_W-1:0]                  now_cycles,
    output logic [$clog2(NUM_SLOTS+1)-1:0]   occupancy,
    output logic [15:0]                      reject_count,
    output logic [15:0]                      orphan_count
);
    localparam int IW = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
    localparam int OW = $clog2(NUM_SLOTS + 1);

    slot_state_e                    st_q [NUM_SLOTS];
    slot_state_e                    st_d [NUM_SLOTS];
    logic [NUM_SLOTS-1:0][ID_W-1:0] id_q, id_d;
    logic [NUM_SLOTS-1:0][TS_W-1:0] dl_q, dl_d;
    logic [NUM_SLOTS-1:0][1:0]      res_q, res_d;
    issue_state_e                   fsm_q, fsm_d;
    logic [IW-1:0]                  sel_q, sel_d;
    logic [ID_W-1:0]                gid_q, gid_d, evt_id_q, evt_id_d;
    logic [1:0]                     pauli_q, pauli_d;
    logic                           evt_v_q, evt_v_d, rdy_q, rdy_d;
    logic [7:0]                     evt_c_q, evt_c_d;
    logic [15:0]                    rej_q, rej_d, orph_q, orph_d;
    logic [TS_W-1:0]                now_q;
    logic [NUM_SLOTS-1:0]           exp_m, rdy_m, hit_m, grant;
    logic [IW-1:0]                  free_idx, exp_idx, pick_idx;
    logic                           free_any, exp_any, pick_any, dup, ack_fire;
    logic [OW-1:0]                  occ;

    assign ack_fire = (fsm_q == ISS_ISSUE) && gate_ack;

    // Slot classification from start-of-cycle state; downward scans leave the lowest index.
    always_comb begin
        exp_m    = '0;
        rdy_m    = '0;
        hit_m    = '0;
        free_idx = '0;
        exp_idx  = '0;
        free_any = 1'b0;
        exp_any  = 1'b0;
        dup      = 1'b0;
        occ      = '0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            exp_m[i] = (st_q[i] == SLOT_WAIT_BELL || st_q[i] == SLOT_READY) &&
                       ({1'b0, now_q} + (TS_W+1)'(GUARD) >= {1'b0, dl_q[i]});
            rdy_m[i] = (st_q[i] == SLOT_READY) && !exp_m[i];
            hit_m[i] = bell_valid && (st_q[i] == SLOT_WAIT_BELL) && (id_q[i] == bell_qubit_id) && !exp_m[i];
            if (st_q[i] == SLOT_FREE) begin
                free_any = 1'b1;
                free_idx = IW'(i);
            end else begin
                dup = dup | (id_q[i] == alloc_qubit_id);
                occ = occ + OW'(1);
            end
            if (exp_m[i]) begin
                exp_any = 1'b1;
                exp_idx = IW'(i);
            end
        end
    end

    qhttp_edf_select #(.N(NUM_SLOTS), .TS_W(TS_W), .IW(IW)) u_edf (
        .valid_i    (rdy_m),
        .deadline_i (dl_q),
        .grant_o    (grant),
        .idx_o      (pick_idx),
        .any_o      (pick_any)
    );

    always_comb begin
        st_d     = st_q;
        id_d     = id_q;
        dl_d     = dl_q;
        res_d    = res_q;
        fsm_d    = fsm_q;
        sel_d    = sel_q;
        gid_d    = gid_q;
        pauli_d  = pauli_q;
        evt_v_d  = 1'b0;
        evt_c_d  = '0;
        evt_id_d = '0;
        rej_d    = rej_q;
        orph_d   = orph_q;
        rdy_d    = 1'b0;
        if (ack_fire) begin
            st_d[sel_q] = SLOT_FREE;
            fsm_d       = ISS_IDLE;
            evt_v_d     = 1'b1;
            evt_c_d     = EVT_CORRECTION_APPLIED;
            evt_id_d    = gid_q;
        end else if (exp_any) begin
            st_d[exp_idx] = SLOT_FREE;
            evt_v_d       = 1'b1;
            evt_c_d       = EVT_EXPIRED;
            evt_id_d      = id_q[exp_idx];
        end
        if (fsm_q == ISS_IDLE && pick_any) begin
            fsm_d   = ISS_ISSUE;
            sel_d   = pick_idx;
            gid_d   = id_q[pick_idx];
            pauli_d = res_q[pick_idx];
        end
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (hit_m[i]) begin
                st_d[i]  = SLOT_READY;
                res_d[i] = bell_result;
            end
            if (fsm_q == ISS_IDLE && grant[i])
                st_d[i] = SLOT_ISSUED;
        end
        if (bell_valid && hit_m == '0 && orph_q != 16'hFFFF)
            orph_d = orph_q + 16'd1;
        // Only slots FREE at the start of the cycle are handed out.
        if (alloc_valid && rdy_q && free_any) begin
            if ((alloc_priority > 8'(PRIO_MAX) && !emergency_override) || dup) begin
                if (rej_q != 16'hFFFF)
                    rej_d = rej_q + 16'd1;
            end else begin
                st_d[free_idx] = SLOT_WAIT_BELL;
                id_d[free_idx] = alloc_qubit_id;
                dl_d[free_idx] = alloc_deadline;
            end
        end
        for (int i = 0; i < NUM_SLOTS; i++)
            rdy_d = rdy_d | (st_d[i] == SLOT_FREE);
    end

    always_ff @(posedge clk_1g or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_SLOTS; i++)
                st_q[i] <= SLOT_FREE;
            id_q     <= '0;
            dl_q     <= '0;
            res_q    <= '0;
            fsm_q    <= ISS_IDLE;
            sel_q    <= '0;
            gid_q    <= '0;
            pauli_q  <= '0;
            evt_v_q  <= 1'b0;
            evt_c_q  <= '0;
            evt_id_q <= '0;
            rdy_q    <= 1'b0;
            rej_q    <= '0;
            orph_q   <= '0;
            now_q    <= '0;
        end else begin
            st_q     <= st_d;
            id_q     <= id_d;
            dl_q     <= dl_d;
            res_q    <= res_d;
            fsm_q    <= fsm_d;
            sel_q    <= sel_d;
            gid_q    <= gid_d;
            pauli_q  <= pauli_d;
            evt_v_q  <= evt_v_d;
            evt_c_q  <= evt_c_d;
            evt_id_q <= evt_id_d;
            rdy_q    <= rdy_d;
            rej_q    <= rej_d;
            orph_q   <= orph_d;
            now_q    <= now_q + TS_W'(1);
        end
    end

    assign alloc_ready   = rdy_q;
    assign apply_gate    = (fsm_q == ISS_ISSUE);
    assign pauli_gate    = pauli_q;
    assign gate_qubit_id = gid_q;
    assign evt_valid     = evt_v_q;
    assign evt_code      = evt_c_q;
    assign evt_qubit_id  = evt_id_q;
    assign now_cycles    = now_q;
    assign occupancy     = occ;
    assign reject_count  = rej_q;
    assign orphan_count  = orph_q;
endmodule

// File: tb/tb_qhttp_session_scheduler.sv
// tb_qhttp_session_scheduler: directed table of per-cycle vectors plus hand-written
// sequences for expiry, admission, full occupancy and mid-issue reset.
module tb_qhttp_session_scheduler;
    logic         clk_1g = 1'b0;
    logic         rst_n = 1'b0;
    logic         alloc_valid, alloc_ready, emergency_override, bell_valid, apply_gate, gate_ack, evt_valid;
    logic [127:0] alloc_qubit_id, bell_qubit_id, gate_qubit_id, evt_qubit_id;
    logic [63:0]  alloc_deadline, now_cycles;
    logic [7:0]   alloc_priority, evt_code;
    logic [1:0]   bell_result, pauli_gate;
    logic [3:0]   occupancy;
    logic [15:0]  reject_count, orphan_count;
    int checks = 0;
    int errors = 0;

    typedef struct {
        int av, aid, adl, pr, bv, bid, br, ack;
        int ap, pg, gid, ev, ec, eid, occ, rdy;
    } vec_t;
    vec_t v [19];

    qhttp_session_scheduler dut (
        .clk_1g(clk_1g), .rst_n(rst_n),
        .alloc_valid(alloc_valid), .alloc_ready(alloc_ready), .alloc_qubit_id(alloc_qubit_id),
        .alloc_deadline(alloc_deadline), .alloc_priority(alloc_priority), .emergency_override(emergency_override),
        .bell_valid(bell_valid), .bell_qubit_id(bell_qubit_id), .bell_result(bell_result),
        .apply_gate(apply_gate), .pauli_gate(pauli_gate), .gate_qubit_id(gate_qubit_id), .gate_ack(gate_ack),
        .evt_valid(evt_valid), .evt_code(evt_code), .evt_qubit_id(evt_qubit_id),
        .now_cycles(now_cycles), .occupancy(occupancy),
        .reject_count(reject_count), .orphan_count(orphan_count)
    );

    always #5 clk_1g = ~clk_1g;

    task automatic step();
        @(posedge clk_1g);
        #1;
    endtask

    task automatic clr();
        alloc_valid = 0; alloc_qubit_id = '0; alloc_deadline = '0; alloc_priority = '0;
        emergency_override = 0; bell_valid = 0; bell_qubit_id = '0; bell_result = '0; gate_ack = 0;
    endtask

    task automatic alloc(input int id, input int dl, input int pr, input bit ovr);
        alloc_valid = 1; alloc_qubit_id = 128'(id); alloc_deadline = 64'(dl);
        alloc_priority = 8'(pr); emergency_override = ovr;
    endtask

    task automatic bell(input int id, input int res);
        bell_valid = 1; bell_qubit_id = 128'(id); bell_result = 2'(res);
    endtask

    task automatic chk(input string n, input logic [127:0] a, input logic [127:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", n, a, e);
        end
    endtask

    task automatic do_reset();
        rst_n = 0;
        clr();
        step();
        step();
        rst_n = 1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        v[0]  = '{0,0,0,0,       0,0,0,0, 0,0,0,       0,0,0,    0,1};
        v[1]  = '{1,1,1000,10,   0,0,0,0, 0,0,0,       0,0,0,    1,1};
        v[2]  = '{0,0,0,0,       1,1,2,0, 0,0,0,       0,0,0,    1,1};
        v[3]  = '{0,0,0,0,       0,0,0,0, 1,2,1,       0,0,0,    1,1};
        v[4]  = '{0,0,0,0,       0,0,0,0, 1,2,1,       0,0,0,    1,1};
        v[5]  = '{0,0,0,0,       0,0,0,1, 0,0,0,       1,4,1,    0,1};
        v[6]  = '{0,0,0,0,       0,0,0,0, 0,0,0,       0,0,0,    0,1};
        v[7]  = '{1,7,2000,5,    0,0,0,0, 0,0,0,       0,0,0,    1,1};
        v[8]  = '{0,0,0,0,       1,7,1,0, 0,0,0,       0,0,0,    1,1};
        v[9]  = '{1,'hB,500,20,  0,0,0,0, 1,1,7,       0,0,0,    2,1};
        v[10] = '{1,'hC,300,30,  0,0,0,0, 1,1,7,       0,0,0,    3,1};
        v[11] = '{0,0,0,0,       1,'hB,3,0, 1,1,7,     0,0,0,    3,1};
        v[12] = '{0,0,0,0,       1,'hC,0,0, 1,1,7,     0,0,0,    3,1};
        v[13] = '{0,0,0,0,       0,0,0,1, 0,0,0,       1,4,7,    2,1};
        v[14] = '{0,0,0,0,       0,0,0,0, 1,0,'hC,     0,0,0,    2,1};
        v[15] = '{0,0,0,0,       0,0,0,0, 1,0,'hC,     0,0,0,    2,1};
        v[16] = '{0,0,0,0,       0,0,0,1, 0,0,0,       1,4,'hC,  1,1};
        v[17] = '{0,0,0,0,       0,0,0,0, 1,3,'hB,     0,0,0,    1,1};
        v[18] = '{0,0,0,0,       0,0,0,1, 0,0,0,       1,4,'hB,  0,1};

        clr();
        step();
        step();
        chk("rst_alloc_ready", alloc_ready, 0);
        chk("rst_apply_gate", apply_gate, 0);
        chk("rst_evt_valid", evt_valid, 0);
        chk("rst_occupancy", occupancy, 0);
        chk("rst_now", now_cycles, 0);
        chk("rst_counters", {reject_count, orphan_count}, 0);
        rst_n = 1;

        for (int k = 0; k < 19; k++) begin
            alloc(v[k].aid, v[k].adl, v[k].pr, 1'b0);
            alloc_valid = 1'(v[k].av);
            bell_valid = 1'(v[k].bv); bell_qubit_id = 128'(v[k].bid); bell_result = 2'(v[k].br);
            gate_ack = 1'(v[k].ack);
            step();
            chk($sformatf("v%0d_apply_gate", k), apply_gate, 128'(v[k].ap));
            if (v[k].ap != 0) begin
                chk($sformatf("v%0d_pauli_gate", k), pauli_gate, 128'(v[k].pg));
                chk($sformatf("v%0d_gate_qubit_id", k), gate_qubit_id, 128'(v[k].gid));
            end
            chk($sformatf("v%0d_evt_valid", k), evt_valid, 128'(v[k].ev));
            if (v[k].ev != 0) begin
                chk($sformatf("v%0d_evt_code", k), evt_code, 128'(v[k].ec));
                chk($sformatf("v%0d_evt_qubit_id", k), evt_qubit_id, 128'(v[k].eid));
            end
            chk($sformatf("v%0d_occupancy", k), occupancy, 128'(v[k].occ));
            chk($sformatf("v%0d_alloc_ready", k), alloc_ready, 128'(v[k].rdy));
        end
        clr();

        // Expiry: deadline 50 with guard 16 expires once now reaches 34.
        do_reset();
        step();
        alloc('hD, 50, 1, 0);
        step();
        clr();
        chk("exp_occupancy_held", occupancy, 1);
        for (int k = 0; k < 100 && evt_valid !== 1'b1; k++) step();
        chk("exp_evt_valid", evt_valid, 1);
        chk("exp_evt_code", evt_code, 8'h05);
        chk("exp_evt_qubit_id", evt_qubit_id, 'hD);
        chk("exp_evt_time_34_35", (now_cycles == 34 || now_cycles == 35), 1);
        chk("exp_occupancy_freed", occupancy, 0);
        bell('hD, 1);
        step();
        clr();
        chk("exp_late_bell_orphan", orphan_count, 1);
        chk("exp_no_second_evt", evt_valid, 0);

        // Admission gate and duplicate detection.
        alloc('h50, 5000, 150, 0);
        step();
        chk("prio_reject_count", reject_count, 1);
        chk("prio_reject_occ", occupancy, 0);
        alloc('h50, 5000, 150, 1);
        step();
        chk("prio_override_occ", occupancy, 1);
        chk("prio_override_rej", reject_count, 1);
        alloc('h50, 5000, 5, 0);
        step();
        chk("dup_reject_count", reject_count, 2);
        chk("dup_occ", occupancy, 1);
        alloc('h51, 5000, 100, 0);
        step();
        chk("prio_max_occ", occupancy, 2);
        chk("prio_max_rej", reject_count, 2);
        alloc('h52, 5000, 1, 0);
        bell('h52, 3);
        step();
        clr();
        chk("same_cycle_bell_orphan", orphan_count, 2);
        chk("same_cycle_alloc_occ", occupancy, 3);

        // Full occupancy and recovery after one correction.
        do_reset();
        step();
        for (int i = 0; i < 8; i++) begin
            alloc('h100 + i, 5000, 1, 0);
            step();
        end
        clr();
        chk("full_alloc_ready", alloc_ready, 0);
        chk("full_occupancy", occupancy, 8);
        bell('h103, 2);
        step();
        clr();
        step();
        chk("full_apply_gate", apply_gate, 1);
        chk("full_gate_qubit_id", gate_qubit_id, 'h103);
        chk("full_pauli_gate", pauli_gate, 2);
        chk("full_ready_before_ack", alloc_ready, 0);
        gate_ack = 1;
        step();
        clr();
        chk("full_ack_occ", occupancy, 7);
        chk("full_ack_ready", alloc_ready, 1);
        chk("full_ack_evt_id", evt_qubit_id, 'h103);
        alloc('h1FF, 5000, 1, 0);
        step();
        clr();
        chk("full_refill_occ", occupancy, 8);
        chk("full_refill_ready", alloc_ready, 0);

        // Asynchronous reset while a correction is outstanding.
        do_reset();
        step();
        for (int i = 0; i < 5; i++) begin
            alloc('h200 + i, 5000, 1, 0);
            step();
        end
        clr();
        bell('h2FF, 0);
        step();
        bell('h202, 1);
        step();
        clr();
        step();
        chk("rstmid_apply_before", apply_gate, 1);
        chk("rstmid_orphan_before", orphan_count, 1);
        chk("rstmid_occ_before", occupancy, 5);
        #2;
        rst_n = 0;
        #1;
        chk("rstmid_apply_async", apply_gate, 0);
        chk("rstmid_occ_async", occupancy, 0);
        chk("rstmid_orphan_async", orphan_count, 0);
        step();
        step();
        rst_n = 1;
        step();
        chk("rstmid_post_evt", evt_valid, 0);
        chk("rstmid_post_occ", occupancy, 0);
        chk("rstmid_post_ready", alloc_ready, 1);
        chk("rstmid_post_counters", {reject_count, orphan_count}, 0);
        chk("rstmid_post_now", now_cycles, 1);
        chk("rstmid_post_apply", apply_gate, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/qhttp_session_scheduler.md
Name: qhttp_session_scheduler

Overview:
- Deadline-aware scheduler in front of the QCI Pauli-correction port.
- Holds up to NUM_SLOTS pending teleportation sessions, allocated by the qhttp frame parser.
- Pairs each session with its incoming Bell result and issues corrections to the QCI one at a time, earliest coherence deadline first.
- Evicts sessions that can no longer meet their deadline; applies the constitutional priority gate (Art. 13) at allocation.

Parameters:
- NUM_SLOTS, 8, number of concurrent session slots.
- ID_W, 128, qubit identifier width.
- TS_W, 64, timestamp/deadline width in clk_1g cycles.
- PRIO_MAX, 100, highest priority value admitted without emergency override.
- GUARD, 16, cycles of margin required before deadline for a session to stay schedulable.

Ports:
- clk_1g in 1: single clock.
- rst_n in 1: reset, asynchronous, active-low.
- alloc_valid in 1: allocation request.
- alloc_ready out 1: a free slot exists.
- alloc_qubit_id in ID_W: session qubit.
- alloc_deadline in TS_W: absolute coherence deadline.
- alloc_priority in 8: constitutional priority.
- emergency_override in 1: bypasses the priority check.
- bell_valid in 1: Bell measurement result arriving.
- bell_qubit_id in ID_W: Bell result qubit.
- bell_result in 2: Pauli selector.
- apply_gate out 1: correction request to QCI.
- pauli_gate out 2: gate to apply.
- gate_qubit_id out ID_W: target qubit.
- gate_ack in 1: QCI accepted correction.
- evt_valid out 1: one-cycle event pulse.
- evt_code out 8: 0x04 CORRECTION_APPLIED, 0x05 EXPIRED.
- evt_qubit_id out ID_W: event subject.
- now_cycles out TS_W: free-running time base.
- occupancy out $clog2(NUM_SLOTS+1): non-FREE slots.
- reject_count out 16: saturating count of rejected allocations.
- orphan_count out 16: saturating count of unmatched Bell results.

Behaviour:
- Reset values: all outputs 0, except alloc_ready=1 one cycle after reset release. All slots FREE. now_cycles=0.
- Reset is asynchronous and applies mid-operation: apply_gate drops immediately and all sessions are discarded with no events.
- now_cycles increments every cycle. Wrap at 2^TS_W is unsupported (584 years at 1 GHz).
- Slot states: FREE, WAIT_BELL, READY, ISSUED.
- alloc_ready is registered: 1 iff at least one slot is FREE.
- Allocation handshake fires on alloc_valid & alloc_ready.
- Allocation is rejected (reject_count++, nothing stored) when alloc_priority > PRIO_MAX and !emergency_override, or when the qubit_id matches a non-FREE slot.
- Otherwise the lowest-index FREE slot becomes WAIT_BELL and stores id and deadline.
- Bell handling:
  - bell_valid matching a WAIT_BELL slot: slot becomes READY and stores bell_result.
  - Matching no slot, or a READY/ISSUED slot: orphan_count++.
  - Matching uses slot state at the start of the cycle, so a Bell result in the same cycle as its own allocation counts as orphan.
- Issue FSM states: IDLE, ISSUE.
  - IDLE: when any READY slot exists, select the one with minimum deadline (ties go to the lowest index). Mark it ISSUED, drive apply_gate=1 with pauli_gate and gate_qubit_id, go to ISSUE.
  - ISSUE: hold apply_gate and its payload stable until gate_ack. On ack: slot becomes FREE, apply_gate=0 next cycle, CORRECTION_APPLIED event next cycle, return to IDLE.
  - Minimum latency is Bell accept at cycle t, slot READY at t+1, apply_gate=1 at t+2.
- Expiry:
  - A WAIT_BELL or READY slot with now_cycles + GUARD >= deadline is expired. The compare is done in TS_W+1 bits.
  - At most one expiry per cycle, lowest index first. The slot goes FREE and an EXPIRED event fires.
  - ISSUED slots never expire.
- Event channel carries one event per cycle. CORRECTION_APPLIED wins. An expiry that loses arbitration stays pending (the slot remains occupied) and retries next cycle.
- Simultaneous events in one cycle:
  - A slot freed by ack or expiry is not reusable by an allocation in the same cycle.
  - Expiry of a slot overrides a Bell match to it in the same cycle; the Bell result counts as orphan.
- Counters saturate at 0xFFFF.

Decomposition:
- Shared package qhttp_pkg holds:
  - message/event codes 0x01–0x05;
  - slot state enum;
  - issue FSM enum;
  - ID_W/TS_W defaults.
- Sub-module qhttp_edf_select: combinational earliest-deadline selector over NUM_SLOTS (valid mask, deadlines) producing a one-hot grant and index, lowest index on tie.

Test Plan:
- Alloc id A=0x1, deadline 1000, prio 10; Bell A result 2'b10 at cycle 10 -> apply_gate=1, pauli_gate=2'b10, gate_qubit_id=0x1 at cycle 12; ack at 15 -> evt 0x04 id 0x1 at 16, occupancy back to 0.
- Slots B (deadline 500) and C (deadline 300) both READY in the same cycle -> C issued first, B issued only after C's ack.
- Alloc D deadline 50, no Bell, GUARD=16 -> evt 0x05 id D when now_cycles reaches 34; a later Bell for D -> orphan_count=1.
- Alloc prio 150 without override -> reject_count=1, occupancy unchanged; same request with emergency_override=1 -> accepted, occupancy=1.
- Fill 8 slots -> alloc_ready=0; ack one correction -> alloc_ready=1 one cycle after the slot frees.
- Assert rst_n=0 while in ISSUE with 5 slots occupied -> apply_gate=0 immediately; after release occupancy=0, no evt_valid, counters 0.
